// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   state_t / ST_*   : arbiter FSM state encoding
//   owner_t / OWN_*  : requester identity (CPU or debug/loader port)
//   WAIT_CNT_W       : width of the saturating CPU wait counter
package dmem_port_arbiter_pkg;

  localparam int WAIT_CNT_W = 16;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_GNT_CPU = 3'd1;
  localparam state_t ST_GNT_DBG = 3'd2;
  localparam state_t ST_RD_CPU  = 3'd3;
  localparam state_t ST_RD_DBG  = 3'd4;

  typedef logic owner_t;
  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way winner select for the data-memory port.
//   req0  : CPU request (owner OWN_CPU)
//   req1  : debug request (owner OWN_DBG)
//   last  : owner served by the previous grant
//   fixed : 1 = CPU wins ties, 0 = round-robin on ties
//   any   : at least one request present
//   pick  : winning owner (meaningful only when any = 1)
module dmem_port_arbiter_rr_pick2
  import dmem_port_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  input  logic   fixed,
  output logic   any,
  output owner_t pick
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      // Tie: either the CPU by priority, or whoever was not served last.
      if (fixed) pick = OWN_CPU;
      else       pick = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else begin
      pick = req1 ? OWN_DBG : OWN_CPU;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single data-memory port (synchronous-read RAM, 1-cycle
// latency) shared by the CPU load/store path and the debug/loader port.
//   clock, reset             : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU request, level, held until cpu_gnt
//   cpu_gnt, cpu_rvalid      : one-cycle grant / read-data-valid pulses
//   cpu_rdata, cpu_stall     : read data (held after rvalid), FSM stall
//   dbg_*                    : debug port, same handshake as the CPU
//   mem_address/data/wren/rden, mem_q : RAM data-side interface
//   cnt_clr, wait_count      : clear / saturating count of CPU stall cycles
//   busy                     : FSM is not idle
// Handshake: a request is a level held until its gnt pulse and dropped at
// the edge that ends the gnt cycle. Arbitration happens only in IDLE, where
// the winner's we/addr/wdata are latched; later changes of the request
// inputs are ignored. gnt follows one cycle after the latch, and for a read
// rvalid follows one cycle after gnt with rdata = mem_q.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [DW-1:0]         cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DW-1:0]         cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [AW-1:0]         dbg_addr,
  input  logic [DW-1:0]         dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DW-1:0]         dbg_rdata,
  output logic [AW-1:0]         mem_address,
  output logic [DW-1:0]         mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DW-1:0]         mem_q,
  input  logic                  cnt_clr,
  output logic [WAIT_CNT_W-1:0] wait_count,
  output logic                  busy
);

  state_t         state;
  state_t         state_next;
  owner_t         last_owner;
  owner_t         pick;
  logic           any_req;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  dbg_rdata_q;

  dmem_port_arbiter_rr_pick2 u_pick (
    .req0  (cpu_req),
    .req1  (dbg_req),
    .last  (last_owner),
    .fixed (FIXED_PRIO != 0),
    .any   (any_req),
    .pick  (pick)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) state_next = (pick == OWN_CPU) ? ST_GNT_CPU : ST_GNT_DBG;
      end
      ST_GNT_CPU: state_next = lat_we ? ST_IDLE : ST_RD_CPU;
      ST_GNT_DBG: state_next = lat_we ? ST_IDLE : ST_RD_DBG;
      ST_RD_CPU:  state_next = ST_IDLE;
      ST_RD_DBG:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs. The memory address/data always reflect the latched request so
  // they hold their last value outside the grant cycle.
  always_comb begin
    cpu_gnt     = (state == ST_GNT_CPU);
    dbg_gnt     = (state == ST_GNT_DBG);
    cpu_rvalid  = (state == ST_RD_CPU);
    dbg_rvalid  = (state == ST_RD_DBG);
    mem_address = lat_addr;
    mem_data    = lat_wdata;
    mem_wren    = ((state == ST_GNT_CPU) || (state == ST_GNT_DBG)) &&  lat_we;
    mem_rden    = ((state == ST_GNT_CPU) || (state == ST_GNT_DBG)) && !lat_we;
    cpu_rdata   = (state == ST_RD_CPU) ? mem_q : cpu_rdata_q;
    dbg_rdata   = (state == ST_RD_DBG) ? mem_q : dbg_rdata_q;
    // A write completes in its grant cycle, a read only once data returns.
    cpu_stall   = cpu_req && (state != ST_RD_CPU) && !((state == ST_GNT_CPU) && cpu_we);
    busy        = (state != ST_IDLE);
  end

  // Request latch at arbitration. last_owner resets to DBG so the CPU wins
  // the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_DBG;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if ((state == ST_IDLE) && any_req) begin
      last_owner <= pick;
      if (pick == OWN_CPU) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
      end else begin
        lat_we    <= dbg_we;
        lat_addr  <= dbg_addr;
        lat_wdata <= dbg_wdata;
      end
    end
  end

  // Read-data capture so each requester sees its last read after rvalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == ST_RD_CPU) cpu_rdata_q <= mem_q;
      if (state == ST_RD_DBG) dbg_rdata_q <= mem_q;
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_count <= '0;
    end else if (cnt_clr) begin
      wait_count <= '0;
    end else if (cpu_stall && (wait_count != '1)) begin
      wait_count <= wait_count + WAIT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a transaction-timeline
// reference model, a behavioural RAM and literal expectations.
module tb_dmem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       cpu_req = 0, cpu_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0;
  logic       cpu_gnt, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_rdata;
  logic       dbg_req = 0, dbg_we = 0;
  logic [7:0] dbg_addr = 0, dbg_wdata = 0;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic [7:0] mem_address, mem_data;
  logic       mem_wren, mem_rden;
  logic [7:0] mem_q = 0;
  logic       cnt_clr = 0;
  logic [15:0] wait_count;
  logic       busy;

  dmem_port_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_q(mem_q), .cnt_clr(cnt_clr), .wait_count(wait_count), .busy(busy)
  );

  // Fixed-priority instance with its own stimulus.
  logic       f_cpu_req = 0, f_dbg_req = 0;
  logic [7:0] f_cpu_addr = 8'h01, f_dbg_addr = 8'h02, f_wdata = 8'h00, f_mem_q = 8'h00;
  logic       f_cpu_gnt, f_cpu_rvalid, f_cpu_stall, f_dbg_gnt, f_dbg_rvalid;
  logic [7:0] f_cpu_rdata, f_dbg_rdata, f_mem_address, f_mem_data;
  logic       f_mem_wren, f_mem_rden, f_busy;
  logic [15:0] f_wait_count;

  dmem_port_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset(reset),
    .cpu_req(f_cpu_req), .cpu_we(1'b1), .cpu_addr(f_cpu_addr), .cpu_wdata(f_wdata),
    .cpu_gnt(f_cpu_gnt), .cpu_rvalid(f_cpu_rvalid), .cpu_rdata(f_cpu_rdata), .cpu_stall(f_cpu_stall),
    .dbg_req(f_dbg_req), .dbg_we(1'b1), .dbg_addr(f_dbg_addr), .dbg_wdata(f_wdata),
    .dbg_gnt(f_dbg_gnt), .dbg_rvalid(f_dbg_rvalid), .dbg_rdata(f_dbg_rdata),
    .mem_address(f_mem_address), .mem_data(f_mem_data), .mem_wren(f_mem_wren), .mem_rden(f_mem_rden),
    .mem_q(f_mem_q), .cnt_clr(1'b0), .wait_count(f_wait_count), .busy(f_busy)
  );

  // ---------------- behavioural RAM ----------------
  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h3C;
  endfunction

  logic [7:0] ram [256];
  logic       ram_ready = 1'b0;
  always @(posedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_address] <= mem_data;
      if (mem_rden) mem_q <= ram[mem_address];
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each access is a timeline entry: grant cycle, optional read-data cycle.
  // The port is free (arbitration possible) on any cycle not in the entry.
  logic [7:0] ref_mem [256];
  logic       m_mem_init = 1'b0;
  int         m_gnt_cyc = -1, m_rd_cyc = -1;
  logic       m_owner = 1'b0;     // 0 = CPU, 1 = DBG
  logic       m_last = 1'b1;      // owner served last
  logic       m_we = 1'b0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_cpu_rd = 0, m_dbg_rd = 0;
  int         m_wait = 0;

  logic e_cg, e_dg, e_cr, e_dr, e_busy, e_stall, win;
  logic [7:0] e_rd;

  // Monitor records for literal checks
  int         gnt_log[$];
  int         rv_count = 0;
  int         mon_cpu_gnt_cyc = -1, mon_cpu_rv_cyc = -1;
  logic [7:0] mon_cpu_gnt_addr = 0, mon_cpu_rv_data = 0, mon_dbg_rv_data = 0;
  logic       mon_cpu_gnt_wren = 0;
  logic [15:0] mon_cpu_gnt_wait = 0;

  always @(negedge clock) begin
    if (!m_mem_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      m_mem_init = 1'b1;
    end
    if (reset) begin
      m_gnt_cyc = -1; m_rd_cyc = -1; m_last = 1'b1; m_we = 1'b0;
      m_addr = 0; m_wdata = 0; m_cpu_rd = 0; m_dbg_rd = 0; m_wait = 0;
    end else begin
      e_cg   = (cyc == m_gnt_cyc) && !m_owner;
      e_dg   = (cyc == m_gnt_cyc) &&  m_owner;
      e_cr   = (cyc == m_rd_cyc)  && !m_owner;
      e_dr   = (cyc == m_rd_cyc)  &&  m_owner;
      e_busy = e_cg || e_dg || e_cr || e_dr;
      e_rd   = ref_mem[m_addr];
      e_stall = cpu_req && !e_cr && !(e_cg && cpu_we);

      chk("cpu_gnt",     cpu_gnt,     e_cg);
      chk("dbg_gnt",     dbg_gnt,     e_dg);
      chk("cpu_rvalid",  cpu_rvalid,  e_cr);
      chk("dbg_rvalid",  dbg_rvalid,  e_dr);
      chk("cpu_rdata",   cpu_rdata,   e_cr ? e_rd : m_cpu_rd);
      chk("dbg_rdata",   dbg_rdata,   e_dr ? e_rd : m_dbg_rd);
      chk("mem_wren",    mem_wren,    (e_cg || e_dg) && m_we);
      chk("mem_rden",    mem_rden,    (e_cg || e_dg) && !m_we);
      chk("mem_address", mem_address, m_addr);
      chk("mem_data",    mem_data,    m_wdata);
      chk("cpu_stall",   cpu_stall,   e_stall);
      chk("wait_count",  wait_count,  m_wait);
      chk("busy",        busy,        e_busy);

      if (cpu_gnt) begin
        gnt_log.push_back(0);
        mon_cpu_gnt_cyc = cyc; mon_cpu_gnt_addr = mem_address;
        mon_cpu_gnt_wren = mem_wren; mon_cpu_gnt_wait = wait_count;
      end
      if (dbg_gnt) gnt_log.push_back(1);
      if (cpu_rvalid) begin mon_cpu_rv_cyc = cyc; mon_cpu_rv_data = cpu_rdata; rv_count++; end
      if (dbg_rvalid) begin mon_dbg_rv_data = dbg_rdata; rv_count++; end

      // Advance the model across the coming edge.
      if ((e_cg || e_dg) && m_we) ref_mem[m_addr] = m_wdata;
      if (e_cr) m_cpu_rd = e_rd;
      if (e_dr) m_dbg_rd = e_rd;
      if (cnt_clr) m_wait = 0;
      else if (e_stall && m_wait < 65535) m_wait = m_wait + 1;
      if (!e_busy && (cpu_req || dbg_req)) begin
        if (cpu_req && dbg_req) win = !m_last;   // not the one served last
        else                    win = dbg_req;
        m_owner = win; m_last = win;
        m_we    = win ? dbg_we : cpu_we;
        m_addr  = win ? dbg_addr : cpu_addr;
        m_wdata = win ? dbg_wdata : cpu_wdata;
        m_gnt_cyc = cyc + 1;
        m_rd_cyc  = m_we ? -1 : cyc + 2;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; raise the request now, drop it after the gnt cycle.
  task automatic cpu_do(input logic we, input logic [7:0] a, input logic [7:0] d,
                        output int t_req, output int t_gnt);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; t_req = cyc; t_gnt = -1;
    for (int i = 0; i < 50 && t_gnt < 0; i++) begin
      @(negedge clock);
      if (cpu_gnt) t_gnt = cyc;
    end
    if (t_gnt < 0) chk("cpu_gnt_timeout", 0, 1);
    @(posedge clock); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dbg_do(input logic we, input logic [7:0] a, input logic [7:0] d,
                        output int t_req, output int t_gnt);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; t_req = cyc; t_gnt = -1;
    for (int i = 0; i < 50 && t_gnt < 0; i++) begin
      @(negedge clock);
      if (dbg_gnt) t_gnt = cyc;
    end
    if (t_gnt < 0) chk("dbg_gnt_timeout", 0, 1);
    @(posedge clock); #1;
    dbg_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int tr, tg, c_r1, c_g1, c_r2, c_g2, d_r1, d_g1, d_r2, d_g2, t0, nlog, nrv, fc, fd;

    // Reset state
    @(negedge clock);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wait_count", wait_count, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // CPU write then read back of 8'h10
    cpu_do(1'b1, 8'h10, 8'hA5, tr, tg);
    chk("wr_gnt_latency", tg - tr, 1);
    chk("wr_gnt_addr", mon_cpu_gnt_addr, 8'h10);
    chk("wr_gnt_wren", mon_cpu_gnt_wren, 1);
    cpu_do(1'b0, 8'h10, 8'h00, tr, tg);
    @(negedge clock); #1;
    chk("rd_rvalid_latency", mon_cpu_rv_cyc - tr, 2);
    chk("rd_data_10", mon_cpu_rv_data, 8'hA5);

    // Ties right after reset: CPU, DBG, CPU, then DBG alone
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
    t0 = cyc; nlog = gnt_log.size();
    fork
      begin cpu_do(1'b1, 8'h50, 8'h11, c_r1, c_g1); cpu_do(1'b1, 8'h52, 8'h33, c_r2, c_g2); end
      begin dbg_do(1'b1, 8'h51, 8'h22, d_r1, d_g1); dbg_do(1'b1, 8'h53, 8'h44, d_r2, d_g2); end
    join
    chk("tie1_cpu_gnt", c_g1 - t0, 1);
    chk("tie2_dbg_gnt", d_g1 - t0, 3);
    chk("tie3_cpu_gnt", c_g2 - t0, 5);
    chk("tail_dbg_gnt", d_g2 - t0, 7);
    chk("tie_log_len", gnt_log.size() - nlog, 4);

    // Short table: debug patches memory, CPU reads it back
    for (int i = 0; i < 4; i++) begin
      dbg_do(1'b1, 8'(8'h60 + i), 8'(8'h90 + i), tr, tg);
      cpu_do(1'b0, 8'(8'h60 + i), 8'h00, tr, tg);
      @(negedge clock); #1;
      chk("patch_readback", mon_cpu_rv_data, 32'(8'h90 + i));
      next_cycle();
    end

    // Clear the counter, then CPU read collides with a debug read in progress
    cnt_clr = 1'b1;
    next_cycle(); cnt_clr = 1'b0;
    chk("cnt_clr_zero", wait_count, 0);
    fork
      dbg_do(1'b0, 8'h20, 8'h00, d_r1, d_g1);
      begin
        repeat (2) @(posedge clock);
        #1 cpu_do(1'b0, 8'h21, 8'h00, c_r1, c_g1);
      end
    join
    @(negedge clock); #1;
    chk("collide_wait_at_gnt", mon_cpu_gnt_wait, 2);
    chk("collide_dbg_data", mon_dbg_rv_data, 8'h1C);
    chk("collide_cpu_data", mon_cpu_rv_data, 8'h1D);
    chk("collide_cpu_gnt_lat", c_g1 - c_r1, 2);

    // Reset in the middle of a CPU write grant
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hFF;
    nlog = gnt_log.size(); nrv = rv_count;
    next_cycle();
    reset = 1'b1;
    #1;
    chk("midrst_wren", mem_wren, 0);
    chk("midrst_gnt", cpu_gnt, 0);
    chk("midrst_busy", busy, 0);
    cpu_req = 1'b0;
    next_cycle(); reset = 1'b0;
    repeat (4) next_cycle();
    chk("midrst_no_gnt", gnt_log.size() - nlog, 0);
    chk("midrst_no_rvalid", rv_count - nrv, 0);
    dbg_do(1'b0, 8'h30, 8'h00, tr, tg);
    @(negedge clock); #1;
    chk("midrst_mem_30", mon_dbg_rv_data, 8'h0C);
    next_cycle();

    // Address change after the latch is ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40; t0 = cyc;
    next_cycle();
    cpu_addr = 8'h41;
    @(negedge clock); #1;
    chk("chg_gnt_cycle", mon_cpu_gnt_cyc - t0, 1);
    chk("chg_gnt_addr", mon_cpu_gnt_addr, 8'h40);
    next_cycle(); cpu_req = 1'b0;
    @(negedge clock); #1;
    chk("chg_rdata", mon_cpu_rv_data, 8'h7C);
    next_cycle();

    // Saturation of the wait counter
    force dut.wait_count = 16'hFFFD;
    m_wait = 16'hFFFD;
    #1 release dut.wait_count;
    next_cycle();
    cpu_do(1'b0, 8'h70, 8'h00, tr, tg);
    cpu_do(1'b0, 8'h71, 8'h00, tr, tg);
    @(negedge clock); #1;
    chk("sat_wait_count", wait_count, 16'hFFFF);
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle(); cnt_clr = 1'b0;
    chk("sat_clear", wait_count, 0);

    // Fixed priority: both requesters hold write requests continuously
    f_cpu_req = 1'b1; f_dbg_req = 1'b1; fc = 0; fd = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      if (f_cpu_gnt) fc++;
      if (f_dbg_gnt) fd++;
    end
    next_cycle();
    f_cpu_req = 1'b0; f_dbg_req = 1'b0;
    chk("fixed_cpu_grants", fc, 3);
    chk("fixed_dbg_grants", fd, 0);

    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
